// File: rtl/block_mem_responder_if.sv
// Block refill/writeback bus between the data cache (master) and the backing store (slave).
// Carries the request, the response pulse and the terminal flush handshake.
interface block_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_BITS = 1024
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BLOCK_BITS-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_write;
    logic [BLOCK_BITS-1:0] resp_rdata;
    logic                  resp_err;
    logic                  flush_req;
    logic                  flush_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, flush_req,
        input  req_ready, resp_valid, resp_write, resp_rdata, resp_err, flush_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, flush_req,
        output req_ready, resp_valid, resp_write, resp_rdata, resp_err, flush_done
    );
endinterface

// File: rtl/block_mem_responder.sv
// Backing-store responder: one whole-block read or writeback at a time with a fixed
// miss latency, a one-cycle response pulse, and a terminal flush/halt handshake.
//
// state | meaning
// IDLE  | ready for a request; flush_req takes priority over req_valid
// BUSY  | request captured, latency counter running down to the response
// HALT  | flushed; flush_done high, no further requests until reset
module block_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_BITS  = 7,
    parameter int BLOCK_BITS   = 1024,
    parameter int DEPTH_BLOCKS = 256,
    parameter int LATENCY      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    block_mem_responder_if.slave  bus
);
    localparam int IDX_W   = $clog2(DEPTH_BLOCKS);
    localparam int CNT_W   = $clog2(LATENCY) + 1;
    localparam int TOP_LSB = OFFSET_BITS + IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_write_q, resp_write_d;
    logic                  resp_err_q, resp_err_d;
    logic [BLOCK_BITS-1:0] resp_rdata_q, resp_rdata_d;
    logic                  flush_done_q, flush_done_d;
    logic                  mem_we;

    logic [BLOCK_BITS-1:0] mem [DEPTH_BLOCKS];

    logic [IDX_W-1:0] req_idx;
    logic             req_oor;
    logic             unused_offset;

    assign req_idx       = bus.req_addr[TOP_LSB-1:OFFSET_BITS];
    assign req_oor       = |bus.req_addr[ADDR_WIDTH-1:TOP_LSB];
    assign unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        oor_d        = oor_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_write_d = resp_write_q;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = HALT;
                end else if (ready_q && bus.req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    write_d = bus.req_write;
                    idx_d   = req_idx;
                    oor_d   = req_oor;
                    wdata_d = bus.req_wdata;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_write_d = write_q;
                    resp_err_d   = oor_q;
                    // Out-of-range requests never touch the array; reads return zero.
                    if (oor_q) begin
                        if (!write_q) begin
                            resp_rdata_d = '0;
                        end
                    end else if (write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        resp_rdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so ready stays low through reset and rises on the first edge after it.
        ready_d      = (state_d == IDLE);
        flush_done_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            oor_q        <= 1'b0;
            wdata_q      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            oor_q        <= oor_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Storage is not reset; a reset mid-transaction leaves mem_we low so nothing commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.flush_done = flush_done_q;
endmodule
